// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction descriptor and hazard/forwarding control outputs
// shared between the pipeline front end and fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dst, id_reg_write, id_mem_read, flush,
        input  stall, fwd_a_sel, fwd_b_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dst, id_reg_write, id_mem_read, flush,
        output stall, fwd_a_sel, fwd_b_sel, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for a 5-stage MIPS pipeline.
// Shadows ID/EX, EX/MEM and MEM/WB destination info to steer the EX operand muxes.
module fwd_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_ctrl_if.slave ctrl
);
    logic             idex_valid_q,     idex_valid_d;
    logic [REG_W-1:0] idex_rs_q,        idex_rs_d;
    logic [REG_W-1:0] idex_rt_q,        idex_rt_d;
    logic             idex_use_rs_q,    idex_use_rs_d;
    logic             idex_use_rt_q,    idex_use_rt_d;
    logic [REG_W-1:0] idex_dst_q,       idex_dst_d;
    logic             idex_reg_write_q, idex_reg_write_d;
    logic             idex_mem_read_q,  idex_mem_read_d;

    logic             exmem_valid_q,     exmem_valid_d;
    logic [REG_W-1:0] exmem_dst_q,       exmem_dst_d;
    logic             exmem_reg_write_q, exmem_reg_write_d;
    logic             exmem_mem_read_q,  exmem_mem_read_d;

    logic             memwb_valid_q,     memwb_valid_d;
    logic [REG_W-1:0] memwb_dst_q,       memwb_dst_d;
    logic             memwb_reg_write_q, memwb_reg_write_d;

    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic                  stall;
    logic                  exmem_fwd_ok;
    logic                  memwb_fwd_ok;
    logic                  idex_load_ok;
    logic [1:0][REG_W-1:0] ex_src;
    logic [1:0]            ex_use;
    logic [1:0][REG_W-1:0] id_src;
    logic [1:0]            id_use;
    logic [1:0]            load_hit;
    logic [1:0][1:0]       sel;

    // A load in EX/MEM cannot forward; the stall ensures no real consumer sees it.
    assign exmem_fwd_ok = exmem_valid_q & exmem_reg_write_q & ~exmem_mem_read_q
                        & (exmem_dst_q != '0);
    assign memwb_fwd_ok = memwb_valid_q & memwb_reg_write_q & (memwb_dst_q != '0);
    assign idex_load_ok = idex_valid_q & idex_mem_read_q & idex_reg_write_q
                        & (idex_dst_q != '0);

    assign ex_src = {idex_rt_q, idex_rs_q};
    assign ex_use = {idex_use_rt_q, idex_use_rs_q};
    assign id_src = {ctrl.id_rt, ctrl.id_rs};
    assign id_use = {ctrl.id_use_rt, ctrl.id_use_rs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic consumer;
            logic ex_hit;
            logic wb_hit;

            assign consumer = idex_valid_q & ex_use[gi];
            assign ex_hit   = consumer & exmem_fwd_ok & (exmem_dst_q == ex_src[gi]);
            assign wb_hit   = consumer & memwb_fwd_ok & (memwb_dst_q == ex_src[gi]);
            assign sel[gi]  = ex_hit ? 2'b01 : (wb_hit ? 2'b10 : 2'b00);

            assign load_hit[gi] = id_use[gi] & (idex_dst_q == id_src[gi]);
        end
    endgenerate

    assign stall = ctrl.id_valid & ~ctrl.flush & idex_load_ok & (|load_hit);

    assign ctrl.stall       = stall;
    assign ctrl.fwd_a_sel   = sel[0];
    assign ctrl.fwd_b_sel   = sel[1];
    assign ctrl.stall_count = stall_count_q;

    always_comb begin
        idex_valid_d     = ctrl.id_valid & ~stall & ~ctrl.flush;
        idex_rs_d        = ctrl.id_rs;
        idex_rt_d        = ctrl.id_rt;
        idex_use_rs_d    = ctrl.id_use_rs;
        idex_use_rt_d    = ctrl.id_use_rt;
        idex_dst_d       = ctrl.id_dst;
        idex_reg_write_d = ctrl.id_reg_write;
        idex_mem_read_d  = ctrl.id_mem_read;

        exmem_valid_d     = idex_valid_q;
        exmem_dst_d       = idex_dst_q;
        exmem_reg_write_d = idex_reg_write_q;
        exmem_mem_read_d  = idex_mem_read_q;

        memwb_valid_d     = exmem_valid_q;
        memwb_dst_d       = exmem_dst_q;
        memwb_reg_write_d = exmem_reg_write_q;

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid_q      <= 1'b0;
            idex_rs_q         <= '0;
            idex_rt_q         <= '0;
            idex_use_rs_q     <= 1'b0;
            idex_use_rt_q     <= 1'b0;
            idex_dst_q        <= '0;
            idex_reg_write_q  <= 1'b0;
            idex_mem_read_q   <= 1'b0;
            exmem_valid_q     <= 1'b0;
            exmem_dst_q       <= '0;
            exmem_reg_write_q <= 1'b0;
            exmem_mem_read_q  <= 1'b0;
            memwb_valid_q     <= 1'b0;
            memwb_dst_q       <= '0;
            memwb_reg_write_q <= 1'b0;
            stall_count_q     <= '0;
        end else begin
            idex_valid_q      <= idex_valid_d;
            idex_rs_q         <= idex_rs_d;
            idex_rt_q         <= idex_rt_d;
            idex_use_rs_q     <= idex_use_rs_d;
            idex_use_rt_q     <= idex_use_rt_d;
            idex_dst_q        <= idex_dst_d;
            idex_reg_write_q  <= idex_reg_write_d;
            idex_mem_read_q   <= idex_mem_read_d;
            exmem_valid_q     <= exmem_valid_d;
            exmem_dst_q       <= exmem_dst_d;
            exmem_reg_write_q <= exmem_reg_write_d;
            exmem_mem_read_q  <= exmem_mem_read_d;
            memwb_valid_q     <= memwb_valid_d;
            memwb_dst_q       <= memwb_dst_d;
            memwb_reg_write_q <= memwb_reg_write_d;
            stall_count_q     <= stall_count_d;
        end
    end
endmodule
